// File: rtl/dmarb_pkg.sv
// dmarb_pkg: shared constants for the data-memory arbiter.
//   - FSM state encoding (IDLE / ACCESS / RD_WAIT)
//   - requester port indices
//   - legal read-latency range and the width of the latency counter
package dmarb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   req  : request vector, bit N = port N
//   last : index of the port most recently granted
//   lock : (DMARB_LOCK_EN only) the last winner holds a lock
//   win  : one-hot winner, all zero when nothing requests
// Optional feature macro: DMARB_LOCK_EN.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
`ifdef DMARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [1:0] win
);

  always_comb begin
    win = req;
    // Contended: the port that did not win last time goes first.
    if (req == 2'b11) win = last ? 2'b01 : 2'b10;
`ifdef DMARB_LOCK_EN
    // A locked winner keeps the port while it keeps requesting.
    if (lock && req[last]) win = last ? 2'b10 : 2'b01;
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one DMEM port between the CPU (port 0) and the
// debug/loader path (port 1). One transaction in flight at a time.
//   clk, rst_n               : clock, async active-low reset
//   reqN/weN/addrN/wdataN    : requester N transaction, held until gntN
//   gntN                     : pulse in the cycle the request hits memory
//   rvalidN/rdataN           : read return; rdataN holds its last value
//   mem_*                    : DMEM strobes, address, data (0 outside ACCESS)
//   busy                     : FSM not in IDLE
//   lock0/lock1              : only with DMARB_LOCK_EN, sticky grant request
// Optional feature macro: DMARB_LOCK_EN.
module dmem_arbiter
  import dmarb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
`ifdef DMARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_ena,
  output logic              mem_r,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Out-of-range latencies are pulled into the supported window.
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;   // port owning the current transaction
  logic              last_q, last_d;     // port most recently granted
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [1:0]        win;
  logic              acc;

`ifdef DMARB_LOCK_EN
  logic lock_q, lock_d;

  always_comb begin
    lock_d = lock_q;
    if (state_q == ST_IDLE && |win) lock_d = win[PORT_DBG] ? lock1 : lock0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
`endif

  rr_arb2 u_arb (
    .req  ({req1, req0}),
    .last (last_q),
`ifdef DMARB_LOCK_EN
    .lock (lock_q),
`endif
    .win  (win)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        // Requester values are captured here; later changes are ignored.
        if (|win) begin
          owner_d = win[PORT_DBG];
          we_d    = win[PORT_DBG] ? we1    : we0;
          addr_d  = win[PORT_DBG] ? addr1  : addr0;
          wdata_d = win[PORT_DBG] ? wdata1 : wdata0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        last_d = owner_q;
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = CNT_W'(LAT);
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // cnt == 1 marks the cycle ACCESS+LAT where mem_rdata is valid.
        if (cnt_q == CNT_W'(1)) begin
          if (owner_q == 1'(PORT_DBG)) rdata1_d = mem_rdata;
          else                         rdata0_d = mem_rdata;
          rvalid_d[owner_q] = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'(PORT_DBG);  // port 0 wins the first contended round
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Memory-side outputs decode straight from state so a reset kills them
  // in the same instant.
  assign acc       = (state_q == ST_ACCESS);
  assign busy      = (state_q != ST_IDLE);
  assign gnt0      = acc && (owner_q == 1'(PORT_CPU));
  assign gnt1      = acc && (owner_q == 1'(PORT_DBG));
  assign mem_ena   = acc;
  assign mem_w     = acc && we_q;
  assign mem_r     = acc && !we_q;
  assign mem_addr  = acc ? addr_q  : '0;
  assign mem_wdata = acc ? wdata_q : '0;
  assign rvalid0   = rvalid_q[PORT_CPU];
  assign rvalid1   = rvalid_q[PORT_DBG];
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with RD_LAT=3.
// Drivers push each issued transaction into a per-port queue; a negedge
// monitor predicts grants from the arbitration rules, pops and compares
// memory strobes, and tracks expected read returns and busy.
module tb_dmem_arbiter;

  localparam int RD_LAT = 3;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req, we;
  logic [1:0][31:0] addr, wdata;
  logic             gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0]      rdata0, rdata1;
  logic             mem_ena, mem_r, mem_w, busy;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic [1:0]       rv;
  logic [1:0][31:0] rd_o;

  assign rv   = {rvalid1, rvalid0};
  assign rd_o = {rdata1, rdata0};

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
`ifdef DMARB_LOCK_EN
    .lock0(1'b0), .lock1(1'b0),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_ena(mem_ena), .mem_r(mem_r), .mem_w(mem_w),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- DMEM model (driven by the DUT's strobes) ----------------
  logic [31:0] dmem [logic [31:0]];
  rd_t         mq[$];

  function automatic logic [31:0] dm_rd(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : 32'h0;
  endfunction

  always @(negedge clk) begin
    if (rst_n && mem_ena) begin
      if (mem_w) dmem[mem_addr] = mem_wdata;
      if (mem_r) mq.push_back('{dm_rd(mem_addr), cyc + RD_LAT});
    end
  end

  // Read data valid only in ACCESS+RD_LAT; random garbage otherwise.
  always @(posedge clk) begin
    rd_t e;
    #1;
    while (mq.size() > 0 && mq[0].due < cyc) e = mq.pop_front();
    if (mq.size() > 0 && mq[0].due == cyc) begin
      e = mq.pop_front();
      mem_rdata = e.data;
    end else begin
      mem_rdata = $urandom;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  txn_t             exp_q [2][$];
  rd_t              rd_q  [2][$];
  logic [31:0]      ref_mem [logic [31:0]];
  logic [1:0]       req_prev = 2'b00;
  logic             busy_prev = 1'b0;
  logic             last_g = 1'b1;
  int               busy_rem = 0;
  logic [1:0][31:0] rexp = '0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  always @(negedge clk) begin
    logic [1:0] exp_g;
    logic       exp_busy;
    int         p;
    txn_t       t;
    rd_t        r;
    if (!rst_n) begin
      check("rst_outs", 32'({gnt1, gnt0, rvalid1, rvalid0, mem_ena, mem_r, mem_w, busy,
                             |mem_addr, |mem_wdata, |rdata0, |rdata1}), 32'h0);
      for (int i = 0; i < 2; i++) begin
        rd_q[i].delete();
        exp_q[i].delete();
      end
      req_prev = 2'b00; busy_prev = 1'b0; last_g = 1'b1; busy_rem = 0; rexp = '0;
    end else begin
      exp_g = 2'b00;
      if (!busy_prev && req_prev != 2'b00)
        exp_g = (req_prev == 2'b11) ? (last_g ? 2'b01 : 2'b10) : req_prev;
      check("gnt", 32'({gnt1, gnt0}), 32'(exp_g));
      if (exp_g != 2'b00) begin
        p = exp_g[1] ? 1 : 0;
        check("sb_has_txn", 32'(exp_q[p].size() != 0), 32'h1);
        if (exp_q[p].size() != 0) begin
          t = exp_q[p].pop_front();
          check("mem_strobes", 32'({mem_ena, mem_w, mem_r}), 32'({1'b1, t.we, !t.we}));
          check("mem_addr", mem_addr, t.addr);
          check("mem_wdata", mem_wdata, t.wdata);
          if (t.we) ref_mem[t.addr] = t.wdata;
          else rd_q[p].push_back('{ref_rd(t.addr), cyc + RD_LAT + 1});
          busy_rem = t.we ? 0 : RD_LAT;
        end
        last_g   = exp_g[1];
        exp_busy = 1'b1;
      end else begin
        check("mem_idle", 32'({mem_ena, mem_r, mem_w, |mem_addr, |mem_wdata}), 32'h0);
        exp_busy = (busy_rem != 0);
        if (busy_rem != 0) busy_rem--;
      end
      check("busy", 32'(busy), 32'(exp_busy));
      for (int i = 0; i < 2; i++) begin
        logic due;
        due = (rd_q[i].size() != 0) && (rd_q[i][0].due == cyc);
        check(i ? "rvalid1" : "rvalid0", 32'(rv[i]), 32'(due));
        if (due) begin
          r = rd_q[i].pop_front();
          rexp[i] = r.data;
        end
        check(i ? "rdata1" : "rdata0", rd_o[i], rexp[i]);
      end
      busy_prev = exp_busy;
      req_prev  = req;
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after gnt.
  task automatic do_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    bit   got;
    got = 1'b0;
    t.we = w; t.addr = a; t.wdata = d;
    exp_q[p].push_back(t);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = (p != 0) ? gnt1 : gnt0;
    end
    if (!got) begin
      n_chk++;
      $display("FAIL gnt_timeout: port %0d got no gnt in 50 cycles, required a gnt", p);
    end
    @(posedge clk); #1;
    req[p] = 1'b0; we[p] = 1'($urandom); addr[p] = $urandom; wdata[p] = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic port_seq(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 3));
      do_txn(p, 1'($urandom), 32'($urandom_range(0, 15)), $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required $finish before 200us");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; mem_rdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    // contended writes straight after reset: order 0,1,0,1,...
    fork
      for (int i = 0; i < 4; i++) do_txn(0, 1'b1, 32'h0, 32'h11);
      for (int i = 0; i < 4; i++) do_txn(1, 1'b1, 32'h4, 32'h22);
    join
    idle(2);

    // loader writes a word, CPU reads it back
    do_txn(1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF);
    do_txn(0, 1'b0, 32'h1001_0000, 32'h0);
    idle(RD_LAT + 2);

    // port 1 back-to-back reads
    for (int i = 0; i < 4; i++) do_txn(1, 1'b0, 32'(i % 2) * 32'h4, $urandom);
    idle(RD_LAT + 2);

    // port 1 read while rdata0 must stay put
    do_txn(1, 1'b0, 32'h1001_0000, 32'h0);
    idle(RD_LAT + 2);

    // randomized traffic from both ports
    fork
      port_seq(0, 40);
      port_seq(1, 40);
    join
    idle(RD_LAT + 3);

    // reset in the second RD_WAIT cycle abandons the read
    do_txn(1, 1'b0, 32'h4, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check("rst_async", 32'({gnt1, gnt0, rvalid1, rvalid0, mem_ena, mem_r, mem_w, busy,
                               |mem_addr, |mem_wdata, |rdata0, |rdata1}), 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    do_txn(0, 1'b1, 32'h3, 32'h55);
    do_txn(0, 1'b0, 32'h3, 32'h0);
    idle(RD_LAT + 4);

    check("sb_drain", 32'(exp_q[0].size() + exp_q[1].size() + rd_q[0].size() + rd_q[1].size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the CPU load/store path; port 1 is the debug/program-loader path.
- Requesters issue word reads and writes with a req/gnt handshake; read data returns on a per-port rvalid pulse.
- Two-way round-robin arbitration; one memory transaction in flight at a time.
- Sits between the CPU/loader and the DMEM, driving DMEM's ena/R/W strobes.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width.
RD_LAT, 1, cycles from the mem_ena+mem_r cycle to mem_rdata valid (legal 1..3).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
req0 / req1  in  1  transaction request; held high until the matching gnt.
we0 / we1  in  1  1 = write, 0 = read.
addr0 / addr1  in  ADDR_W  word address.
wdata0 / wdata1  in  DATA_W  write data.
gnt0 / gnt1  out  1  one-cycle pulse: request accepted and issued to memory this cycle.
rvalid0 / rvalid1  out  1  one-cycle pulse: rdataN valid.
rdata0 / rdata1  out  DATA_W  read data; holds its last value.
mem_ena, mem_r, mem_w  out  1  DMEM enable, read and write strobes.
mem_addr  out  ADDR_W  DMEM address.
mem_wdata  out  DATA_W  DMEM write data.
mem_rdata  in  DATA_W  DMEM read data.
busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0, including rdata0/1; round-robin pointer prefers port 0.
- A reset during ACCESS or RD_WAIT abandons the transaction: no rvalid, no late mem strobe.
- FSM states: IDLE, ACCESS, RD_WAIT.
- IDLE:
  - If only one req is high, pick that port.
  - If both are high, pick the port not most recently granted.
  - Register that port's we/addr/wdata; next state ACCESS.
  - No req: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Drive mem_ena=1, mem_w=we, mem_r=!we, plus the registered mem_addr and mem_wdata.
  - Pulse gnt of the chosen port and update the pointer.
  - Write: next state IDLE.
  - Read: load the latency counter with RD_LAT; next state RD_WAIT.
- RD_WAIT:
  - Decrement the counter each cycle.
  - In the cycle where mem_rdata is valid (ACCESS+RD_LAT), register it into the owner's rdata.
  - Next state IDLE; rvalidN pulses in that IDLE cycle.
- Latency:
  - Write: req to gnt is 1 cycle when uncontended.
  - Read: gnt to rvalid is RD_LAT+1 cycles.
  - Minimum period per port: 2 cycles (write), RD_LAT+2 cycles (read).
- Outside ACCESS, mem_ena/mem_r/mem_w/mem_addr/mem_wdata are driven 0.
- Values are sampled in the IDLE arbitration cycle; requester changes after that are ignored. A req that drops before gnt is allowed and is treated as withdrawn.
- rvalid goes only to the port that issued the read. The other port's rdata is unchanged.
- A starved port waits at most one transaction from the other port.

Optional Feature:
- Macro DMARB_LOCK_EN.
- Defined:
  - Adds inputs lock0 and lock1.
  - If the winning port's lock is high in its arbitration cycle, the next IDLE arbitration grants the same port if it requests, overriding round-robin, until its lock is sampled low.
  - Lock on a non-requesting port has no effect.
- Undefined: lock ports absent; pure round-robin.

Decomposition:
- Package dmarb_pkg: FSM state encoding (IDLE/ACCESS/RD_WAIT), port index constants PORT_CPU=0 and PORT_DBG=1, RD_LAT legal range, latency counter width.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], last, lock (feature only).
  - Output: one-hot win[1:0].
  - Purely combinational; the pointer register lives in dmem_arbiter.

Test Plan:
1. RD_LAT=1; req0 read, addr 0x1001_0000; memory returns 0xDEADBEEF -> ACCESS at cycle 1 with mem_r=1 and that addr; gnt0 at cycle 1; rvalid0=1 at cycle 3 with rdata0=0xDEADBEEF; rvalid1 stays 0.
2. After reset, req0 and req1 both write continuously (addr 0x0/0x4, data 0x11/0x22) -> grant order 0,1,0,1; mem_w=1 each ACCESS with matching addr/data.
3. Only req1 reads back-to-back, RD_LAT=1 -> gnt1 every 3 cycles; busy low only in the arbitration cycles.
4. RD_LAT=3 read on port 1 -> rvalid1 4 cycles after gnt1; busy high 4 cycles; rdata0 unchanged.
5. rst_n low in the second RD_WAIT cycle (RD_LAT=3) -> all outputs 0 immediately; no rvalid after release; a new req0 is granted 1 cycle after its request.
6. DMARB_LOCK_EN; req1 with lock1=1 and req0 both high for 3 transactions, then lock1=0 -> port 1 granted 3 times consecutively, then port 0 next.
